// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the multi-port register file.
// Optional write-to-read forwarding is selected by REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int DEFAULT_NUM_RD = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read lane: enable gating, hard-wired zero register and,
// when REGFILE_BYPASS_EN is defined, forwarding of same-cycle write data.
module regfile_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_en,
  input  logic              i_force_zero,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_mem_data,
`ifdef REGFILE_BYPASS_EN
  input  logic              i_byp0_en,
  input  logic [ADDR_W-1:0] i_byp0_addr,
  input  logic [DATA_W-1:0] i_byp0_data,
  input  logic              i_byp1_en,
  input  logic [ADDR_W-1:0] i_byp1_addr,
  input  logic [DATA_W-1:0] i_byp1_data,
`endif
  output logic [DATA_W-1:0] o_data
);

  always_comb begin
    o_data = '0;
    if (i_en && !i_force_zero && (i_addr != '0)) begin
`ifdef REGFILE_BYPASS_EN
      // Port 1 has write priority, so it also has forwarding priority.
      if (i_byp1_en && (i_byp1_addr == i_addr)) begin
        o_data = i_byp1_data;
      end else if (i_byp0_en && (i_byp0_addr == i_addr)) begin
        o_data = i_byp0_data;
      end else begin
        o_data = i_mem_data;
      end
`else
      o_data = i_mem_data;
`endif
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Two-write, NUM_RD-read register file with a post-reset clear sequence.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to read lanes.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NUM_RD = DEFAULT_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     busy,
  output state_t                   o_dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              w_clr_we;
  logic              w_wen0;
  logic              w_wen1;
  logic              w_rd_zero;
  logic [DATA_W-1:0] r_mem [DEPTH];

  // State register, clear counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
      r_busy    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      if (r_state == CLEAR) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR: if (r_clr_cnt == LAST_ADDR) w_state_nxt = READY;
      READY: w_state_nxt = READY;
    endcase
  end

  // Write qualification; address 0 is never a legal write target.
  always_comb begin
    w_busy_nxt = (w_state_nxt == CLEAR);
    w_clr_we   = !rst && (r_state == CLEAR);
    w_wen0     = !rst && (r_state == READY) && we0 && (waddr0 != '0);
    w_wen1     = !rst && (r_state == READY) && we1 && (waddr1 != '0);
    w_rd_zero  = rst || (r_state == CLEAR);
  end

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= '0;
    end else begin
      if (w_wen0) r_mem[waddr0] <= wdata0;
      if (w_wen1) r_mem[waddr1] <= wdata1;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_lane
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = rd_addr[i*ADDR_W +: ADDR_W];

    regfile_read_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_read_port (
      .i_en        (rd_en[i]),
      .i_force_zero(w_rd_zero),
      .i_addr      (w_addr),
      .i_mem_data  (r_mem[w_addr]),
`ifdef REGFILE_BYPASS_EN
      .i_byp0_en   (w_wen0),
      .i_byp0_addr (waddr0),
      .i_byp0_data (wdata0),
      .i_byp1_en   (w_wen1),
      .i_byp1_addr (waddr1),
      .i_byp1_data (wdata1),
`endif
      .o_data      (rd_data[i*DATA_W +: DATA_W])
    );
  end

  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_regfile_multiport.sv
// Randomised scoreboard bench for regfile_multiport; honours REGFILE_BYPASS_EN.
module tb_regfile_multiport;
  import regfile_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int EW    = NR*DW + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             we0, we1;
  logic [AW-1:0]    waddr0, waddr1;
  logic [DW-1:0]    wdata0, wdata1;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic             busy;
  state_t           dbg_state;

  regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .we1(we1),
    .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: register contents plus remaining clear cycles.
  logic [DW-1:0] model_mem [DEPTH];
  int            clear_left;
  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            cyc      = 0;

  function automatic logic [DW-1:0] exp_lane(int i);
    logic [AW-1:0] a;
    a = rd_addr[i*AW +: AW];
    if (rst || clear_left > 0 || !rd_en[i] || a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we1 && waddr1 == a) return wdata1;
    if (we0 && waddr0 == a) return wdata0;
`endif
    return model_mem[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      clear_left = DEPTH;
      for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
    end else if (clear_left > 0) begin
      clear_left--;
    end else begin
      if (we0 && waddr0 != '0) model_mem[waddr0] = wdata0;
      if (we1 && waddr1 != '0) model_mem[waddr1] = wdata1;
    end
  endtask

  // Driver: inputs are already set; predict, then advance one clock.
  task automatic step();
    logic [EW-1:0] e;
    e[EW-1] = (clear_left > 0);
    for (int i = 0; i < NR; i++) e[i*DW +: DW] = exp_lane(i);
    exp_q.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
  endtask

  task automatic idle();
    rst = 1'b0; we0 = 1'b0; we1 = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    rd_en = '0; rd_addr = '0;
  endtask

  task automatic set_rd(input int lane, input int addr, input logic en);
    rd_addr[lane*AW +: AW] = AW'(addr);
    rd_en[lane] = en;
  endtask

  task automatic rand_inputs(input int rst_pct);
    rst    = ($urandom_range(0, 99) < rst_pct);
    we0    = 1'($urandom_range(0, 1));
    we1    = 1'($urandom_range(0, 1));
    waddr0 = AW'($urandom_range(0, 7));
    waddr1 = ($urandom_range(0, 3) == 0) ? waddr0 : AW'($urandom_range(0, DEPTH-1));
    wdata0 = $urandom();
    wdata1 = $urandom();
    for (int i = 0; i < NR; i++) begin
      if ($urandom_range(0, 2) == 0) set_rd(i, int'(waddr0), 1'($urandom_range(0, 1)));
      else set_rd(i, $urandom_range(0, 7), 1'($urandom_range(0, 3) != 0));
    end
  endtask

  task automatic read_all();
    idle();
    for (int a = 0; a < DEPTH; a += NR) begin
      for (int i = 0; i < NR; i++) set_rd(i, a + i, 1'b1);
      step();
    end
  endtask

  // Monitor: compare each cycle's outputs mid-cycle against the oldest prediction.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [DW-1:0] got;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (busy === e[EW-1]) n_pass++;
      else $display("FAIL busy cyc=%0d got=%0b exp=%0b", cyc, busy, e[EW-1]);
      for (int i = 0; i < NR; i++) begin
        got = rd_data[i*DW +: DW];
        n_checks++;
        if (got === e[i*DW +: DW]) n_pass++;
        else $display("FAIL lane%0d cyc=%0d addr=%0d got=%h exp=%h",
                      i, cyc, rd_addr[i*AW +: AW], got, e[i*DW +: DW]);
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    #1;

    // Reset held one more cycle, then a clear interrupted at cycle 10.
    rst = 1'b1; set_rd(0, 4, 1'b1); set_rd(1, 0, 1'b1);
    step();
    for (int c = 0; c < 10; c++) begin rand_inputs(0); step(); end
    rand_inputs(0); rst = 1'b1;
    step();
    for (int c = 0; c < DEPTH; c++) begin rand_inputs(0); step(); end
    read_all();

    // Basic write then enabled / disabled read.
    idle(); we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    step();
    idle(); set_rd(1, 5, 1'b1); step();
    idle(); set_rd(1, 5, 1'b0); step();

    // Same-address collision, then a write attempt to register 0.
    idle(); we0 = 1'b1; we1 = 1'b1; waddr0 = 5'd7; waddr1 = 5'd7;
    wdata0 = 32'h11; wdata1 = 32'h22;
    step();
    idle(); set_rd(0, 7, 1'b1); set_rd(1, 7, 1'b1); step();
    idle(); we0 = 1'b1; waddr0 = '0; wdata0 = 32'hFFFF; step();
    idle(); set_rd(0, 0, 1'b1); set_rd(1, 0, 1'b1); step();

    // Read of a register in the same cycle it is written.
    idle(); we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h55; set_rd(0, 3, 1'b1); step();
    idle(); set_rd(0, 3, 1'b1); step();

    // Contents lost across a reset in READY.
    idle(); we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'hA5A5A5A5; step();
    idle(); set_rd(0, 9, 1'b1); step();
    idle(); rst = 1'b1; set_rd(0, 9, 1'b1); step();
    idle(); set_rd(0, 9, 1'b1);
    for (int c = 0; c < DEPTH; c++) step();
    step();

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin rand_inputs(1); step(); end
    idle();
    for (int c = 0; c < DEPTH + 1; c++) step();
    read_all();

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain got=%0d exp=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports we0/we1  input  1  write enables, ports 0 and 1.
REQ-007 SHALL have ports waddr0/waddr1  input  ADDR_W  write addresses.
REQ-008 SHALL have ports wdata0/wdata1  input  DATA_W  write data.
REQ-009 SHALL have port rd_en  input  NUM_RD  per-port read enable.
REQ-010 SHALL have port rd_addr  input  NUM_RD*ADDR_W  packed read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-011 SHALL have port rd_data  output  NUM_RD*DATA_W  packed read data, same packing.
REQ-012 SHALL have port busy  output  1  registered; high while the clear sequence runs.

Function
REQ-013 SHALL implement a two-state FSM: CLEAR, READY.
REQ-014 In CLEAR, each cycle SHALL write 0 to mem[clr_cnt] and increment clr_cnt; when clr_cnt == DEPTH-1 the write SHALL occur and next state SHALL be READY.
REQ-015 busy SHALL be 1 in CLEAR and 0 in READY; exactly DEPTH cycles high after rst deasserts.
REQ-016 In CLEAR, we0/we1 SHALL be ignored and every rd_data lane SHALL read 0.
REQ-017 In READY, a write SHALL occur at posedge when weN==1 and waddrN != 0.
REQ-018 Address 0 SHALL never be written; reads of address 0 SHALL return 0.
REQ-019 When both ports write the same nonzero address in one cycle, port 1 SHALL win.
REQ-020 Reads SHALL be combinational (zero latency); lane i SHALL be 0 if rd_en[i]==0, else mem[rd_addr_i].
REQ-021 All read lanes SHALL be independent; any lanes may read the same address concurrently.
REQ-022 Register contents SHALL hold indefinitely absent writes, clear or reset.

Reset
REQ-023 While rst==1, every rd_data lane SHALL be 0 combinationally and writes SHALL be blocked.
REQ-024 At posedge with rst==1: state<=CLEAR, clr_cnt<=0, busy<=1.
REQ-025 rst asserted mid-clear or in READY SHALL restart the clear from address 0.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-027 With REGFILE_BYPASS_EN defined, in READY a read lane with rd_en==1 whose address equals an active nonzero write address SHALL return that cycle's write data (port 1 over port 0).
REQ-028 Without REGFILE_BYPASS_EN, such a read SHALL return the stored (pre-write) value; new value visible next cycle.

Structure
REQ-029 Package regfile_pkg SHALL hold default DATA_W/ADDR_W/NUM_RD constants and the FSM state typedef (CLEAR, READY).
REQ-030 Sub-module regfile_read_port SHALL implement one lane (enable gating, zero-address, bypass mux), instantiated NUM_RD times via generate.
REQ-031 Storage, write logic, clear FSM and counter SHALL reside in regfile_multiport.

Verification
REQ-032 Reset 1 cycle, release -> busy==1 for exactly 32 cycles, 0 on cycle 32; any lane reads 0 throughout.
REQ-033 READY: we0=1 waddr0=5 wdata0=0xDEADBEEF; next cycle rd_addr lane1=5 rd_en=1 -> 0xDEADBEEF; rd_en=0 -> 0.
REQ-034 we0=1/we1=1 both addr 7, data 0x11/0x22 -> next-cycle read of 7 returns 0x22; write to addr 0 with 0xFFFF -> read 0 returns 0.
REQ-035 Same-cycle write addr 3 data 0x55 with read addr 3 (old 0x0) -> 0x55 with REGFILE_BYPASS_EN, 0x0 without.
REQ-036 rst pulse at clear cycle 10 -> busy stays 1 for 32 more cycles; writes during CLEAR leave all registers 0.
REQ-037 Write addr 9 data 0xA5A5A5A5 in READY, then reset -> after clear, read addr 9 returns 0.
